// File: rtl/sha2_uart_pkg.sv
// Shared definitions for the sha2 UART receiver: FSM state encoding,
// baud divider calculation and the 3-sample majority vote.
package sha2_uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

  // Clocks per oversample tick, rounded to nearest and never below one.
  function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
    int den;
    int div;
    den = baud * oversample;
    div = (clk_hz + den / 2) / den;
    return (div < 1) ? 1 : div;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every DIV clocks, parked at zero
// while clr is high so the first tick lands exactly DIV clocks after release.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;

  // divider counter, wraps at DIV-1 and is held at zero by clr
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= CW'(0);
    end else if (clr) begin
      cnt_r <= CW'(0);
    end else if (cnt_r == LAST) begin
      cnt_r <= CW'(0);
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign tick = !clr && (cnt_r == LAST);

endmodule

// File: rtl/sha2_uart_rx.sv
// 8N1 oversampling UART receiver feeding sha2_controller through a one-entry
// valid/ready holding register, with framing and overrun pulses.
module sha2_uart_rx
  import sha2_uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_VA   = SW'(M - 1);
  localparam logic [SW-1:0] S_VB   = SW'(M);
  localparam logic [SW-1:0] S_DEC  = SW'(M + 1);

  logic [1:0]    sync_r;
  logic          rx_s;
  logic          prev_r;
  logic [1:0]    warm_r;
  logic          fall_s;
  uart_state_e   state_r;
  logic [SW-1:0] s_r;
  logic [SW-1:0] s_next_s;
  logic [2:0]    bit_r;
  logic [7:0]    shift_r;
  logic          v_a_r;
  logic          v_b_r;
  logic          vote_s;
  logic          brk_high_r;
  logic          done_r;
  logic          clr_s;
  logic          tick_s;

  assign rx_s     = sync_r[1];
  assign clr_s    = (state_r == IDLE);
  assign s_next_s = (s_r == S_LAST) ? SW'(0) : s_r + SW'(1);
  assign vote_s   = maj3(v_a_r, v_b_r, rx_s);
  // Edge detection waits until the synchroniser and prev_r reflect the real
  // line, so a line held low across reset release is not seen as a start edge.
  assign fall_s   = (warm_r == 2'd3) && prev_r && !rx_s;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .tick (tick_s)
  );

  // two-flop synchroniser, line history and post-reset warm-up counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= 2'b11;
      prev_r <= 1'b1;
      warm_r <= 2'd0;
    end else begin
      sync_r <= {sync_r[0], RX};
      prev_r <= rx_s;
      if (warm_r != 2'd3) begin
        warm_r <= warm_r + 2'd1;
      end
    end
  end

  // capture the first two vote samples; the third is rx_s at the decision tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_a_r <= 1'b1;
      v_b_r <= 1'b1;
    end else if (tick_s) begin
      if (s_r == S_VA) begin
        v_a_r <= rx_s;
      end
      if (s_r == S_VB) begin
        v_b_r <= rx_s;
      end
    end
  end

  // receive FSM, sample counter, shifter and frame-error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      s_r        <= SW'(0);
      bit_r      <= 3'd0;
      shift_r    <= 8'h00;
      brk_high_r <= 1'b0;
      done_r     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      frame_err <= 1'b0;
      case (state_r)
        IDLE: begin
          s_r   <= SW'(0);
          bit_r <= 3'd0;
          if (fall_s) begin
            state_r <= START;
          end
        end
        START: begin
          if (tick_s) begin
            s_r <= s_next_s;
            if (s_r == S_DEC && vote_s) begin
              state_r <= IDLE;
            end else if (s_r == S_LAST) begin
              state_r <= DATA;
            end
          end
        end
        DATA: begin
          if (tick_s) begin
            s_r <= s_next_s;
            if (s_r == S_DEC) begin
              shift_r <= {vote_s, shift_r[7:1]};
            end
            if (s_r == S_LAST) begin
              if (bit_r == 3'd7) begin
                state_r <= STOP;
              end else begin
                bit_r <= bit_r + 3'd1;
              end
            end
          end
        end
        STOP: begin
          if (tick_s) begin
            s_r <= s_next_s;
            if (s_r == S_DEC) begin
              if (vote_s) begin
                done_r  <= 1'b1;
                state_r <= IDLE;
              end else begin
                frame_err  <= 1'b1;
                brk_high_r <= 1'b0;
                state_r    <= BREAK;
              end
            end
          end
        end
        BREAK: begin
          // leave only after the line stayed high across a whole tick period
          if (!rx_s) begin
            brk_high_r <= 1'b0;
          end else if (tick_s) begin
            if (brk_high_r) begin
              state_r <= IDLE;
            end else begin
              brk_high_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // one-entry holding register with overrun detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done_r) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_r;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sha2_uart_rx.sv
// Self-checking bench for sha2_uart_rx: directed frame scenarios plus a
// randomized stream checked against a queue-based expectation.
module tb_sha2_uart_rx;

  localparam int CLK_HZ   = 16_000_000;
  localparam int BAUD     = 1_000_000;
  localparam int OS       = 16;
  localparam int BIT_CLKS = CLK_HZ / BAUD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       RX = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int err_cnt = 0;
  int chk_cnt = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int vcyc = 0;
  int cyc = 0;
  int vrise_cyc = 0;
  logic prev_valid = 1'b0;
  bit rand_rdy = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  sha2_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Observer: sampled mid-cycle, so valid/ready seen here are what the next rising edge uses.
  always @(negedge clk) begin
    #2;
    cyc++;
    if (rst) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (rx_valid) vcyc++;
      if (rx_valid && !prev_valid) vrise_cyc = cyc;
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
    end
    prev_valid = rx_valid;
  end

  task automatic line_clk(input logic v);
    @(negedge clk);
    RX = v;
    if (rand_rdy) rx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) line_clk(1'b1);
  endtask

  // 8N1 frame, 16 clocks per bit; glitch inverts one clock mid-bit of every data bit
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit glitch);
    logic [9:0] fr;
    fr = {stop_v, b, 1'b0};
    for (int i = 0; i < 10; i++)
      for (int c = 0; c < BIT_CLKS; c++)
        line_clk((glitch && i >= 1 && i <= 8 && c == 9) ? ~fr[i] : fr[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_data"}, 32'(rx_data), 32'h0);
    check_eq({tag, "_valid"}, 32'(rx_valid), 32'h0);
    check_eq({tag, "_ferr"}, 32'(frame_err), 32'h0);
    check_eq({tag, "_ovr"}, 32'(overrun), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, ov0, vc0, t0, fe_exp;
    logic [7:0] b;
    bit bad;

    repeat (4) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    idle(10);

    // 1: single frame with consumer always ready
    rx_ready = 1'b1;
    got_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt; vc0 = vcyc; t0 = cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(30);
    check_eq("t1_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check_eq("t1_data", 32'(got_q[0]), 32'hA5);
    check_eq("t1_valid_cycles", 32'(vcyc - vc0), 32'd1);
    check_eq("t1_ferr", 32'(fe_cnt - fe0), 32'd0);
    check_eq("t1_ovr", 32'(ov_cnt - ov0), 32'd0);
    check_eq("t1_latency_window", 32'((vrise_cyc - t0 >= 150) && (vrise_cyc - t0 <= 162)), 32'd1);

    // 2: back-to-back frames with a stalled consumer
    rx_ready = 1'b0;
    got_q.delete();
    ov0 = ov_cnt;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(20);
    #1;
    check_eq("t2_valid_held", 32'(rx_valid), 32'd1);
    check_eq("t2_data_held", 32'(rx_data), 32'h00);
    check_eq("t2_overruns", 32'(ov_cnt - ov0), 32'd2);
    check_eq("t2_no_transfer", 32'(got_q.size()), 32'd0);
    @(negedge clk); rx_ready = 1'b1;
    @(negedge clk); rx_ready = 1'b0;
    idle(3);
    #1;
    check_eq("t2_drain_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check_eq("t2_drain_data", 32'(got_q[0]), 32'h00);
    check_eq("t2_valid_cleared", 32'(rx_valid), 32'd0);

    // 3: short low pulse is rejected as a glitch
    rx_ready = 1'b1;
    got_q.delete();
    fe0 = fe_cnt; vc0 = vcyc;
    for (int i = 0; i < 4; i++) line_clk(1'b0);
    idle(200);
    check_eq("t3_no_valid", 32'(vcyc - vc0), 32'd0);
    check_eq("t3_no_ferr", 32'(fe_cnt - fe0), 32'd0);

    // 4: stop bit low gives a frame error, next frame still good
    got_q.delete();
    fe0 = fe_cnt; vc0 = vcyc;
    send_frame(8'h55, 1'b0, 1'b0);
    idle(30);
    check_eq("t4_ferr", 32'(fe_cnt - fe0), 32'd1);
    check_eq("t4_no_valid", 32'(vcyc - vc0), 32'd0);
    send_frame(8'h12, 1'b1, 1'b0);
    idle(30);
    check_eq("t4_next_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check_eq("t4_next_data", 32'(got_q[0]), 32'h12);
    check_eq("t4_ferr_total", 32'(fe_cnt - fe0), 32'd1);

    // 5: single-clock glitches at mid-bit are outvoted
    got_q.delete();
    send_frame(8'h81, 1'b1, 1'b1);
    idle(30);
    check_eq("t5_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check_eq("t5_data", 32'(got_q[0]), 32'h81);

    // 6: reset in the middle of a frame
    got_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt;
    begin
      logic [9:0] fr;
      fr = {1'b1, 8'h77, 1'b0};
      for (int i = 0; i < 5; i++)
        for (int c = 0; c < BIT_CLKS; c++) line_clk(fr[i]);
      for (int c = 0; c < 8; c++) line_clk(fr[5]);
    end
    @(negedge clk);
    rst = 1'b0;
    RX = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("t6_in_reset");
    @(negedge clk);
    rst = 1'b1;
    idle(20);
    send_frame(8'h09, 1'b1, 1'b0);
    idle(30);
    check_eq("t6_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check_eq("t6_data", 32'(got_q[0]), 32'h09);
    check_eq("t6_no_pulses", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);

    // 7: line held low across reset release is not a start edge
    got_q.delete();
    fe0 = fe_cnt; vc0 = vcyc;
    @(negedge clk);
    rst = 1'b0;
    RX = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 200; i++) line_clk(1'b0);
    idle(30);
    check_eq("t7_no_ferr", 32'(fe_cnt - fe0), 32'd0);
    check_eq("t7_no_valid", 32'(vcyc - vc0), 32'd0);
    send_frame(8'h6B, 1'b1, 1'b0);
    idle(30);
    check_eq("t7_after_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check_eq("t7_after_data", 32'(got_q[0]), 32'h6B);

    // 8: random stream, random gaps, occasional bad stop, random consumer readiness
    got_q.delete();
    exp_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt; fe_exp = 0;
    rand_rdy = 1'b1;
    for (int n = 0; n < 20; n++) begin
      b = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      send_frame(b, !bad, 1'b0);
      if (bad) fe_exp++;
      else exp_q.push_back(b);
      idle($urandom_range(0, 12) + (bad ? 20 : 0));
    end
    rand_rdy = 1'b0;
    rx_ready = 1'b1;
    idle(40);
    check_eq("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq($sformatf("rand_byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    check_eq("rand_ferr", 32'(fe_cnt - fe0), 32'(fe_exp));
    check_eq("rand_ovr", 32'(ov_cnt - ov0), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
